// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: run-control sequencer for the accumulator core.
// Owns the PC and the Start/Ack handshake, stalls on slow data memory, emits the
// per-instruction Commit strobe and keeps saturating cycle/instruction/stall counters.
// Optional build macro: SEQ_SINGLE_STEP_EN adds StepMode/Step inputs for single-stepping.
module seq_run_ctrl #(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned START_PC    = 0,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Branch,
   input  logic [PC_W-1:0]  Target,
   input  logic             MemReq,
   input  logic             MemReady,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic             StepMode,
   input  logic             Step,
`endif
   output logic             Ack,
   output logic             Err,
   output logic [PC_W-1:0]  PC,
   output logic             Commit,
   output logic             ClearFlags,
   output logic [CNT_W-1:0] CycleCt,
   output logic [CNT_W-1:0] InstrCt,
   output logic [CNT_W-1:0] StallCt
);

   // Wide enough to hold the value MEM_TIMEOUT itself.
   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StMemWait,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cycle_q, cycle_d;
   logic [CNT_W-1:0]   instr_q, instr_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic [PC_W-1:0]    pc_next;
   logic               step_ok;

`ifdef SEQ_SINGLE_STEP_EN
   assign step_ok = ~StepMode | Step;
`else
   assign step_ok = 1'b1;
`endif

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Next-state, counter updates and the combinational Commit/ClearFlags strobes.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ack_d      = ack_q;
      err_d      = err_q;
      cycle_d    = cycle_q;
      instr_d    = instr_q;
      stall_d    = stall_q;
      wait_d     = wait_q;
      Commit     = 1'b0;
      ClearFlags = (state_q == StClear);
      pc_next    = Branch ? Target : pc_q + 1'b1;

      if (Start) begin
         // Restart wins over everything else, in every state.
         state_d = StClear;
         pc_d    = PC_W'(START_PC);
         ack_d   = 1'b0;
         err_d   = 1'b0;
         cycle_d = '0;
         instr_d = '0;
         stall_d = '0;
         wait_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StClear: state_d = StRun;
            StRun: begin
               if (step_ok) begin
                  cycle_d = sat_inc(cycle_q);
                  if (Halt) begin
                     // Halt itself does not retire.
                     state_d = StDone;
                     ack_d   = 1'b1;
                  end else if (MemReq && !MemReady) begin
                     state_d = StMemWait;
                     wait_d  = WaitW'(1);
                  end else begin
                     Commit  = 1'b1;
                     instr_d = sat_inc(instr_q);
                     pc_d    = pc_next;
                  end
               end
            end
            StMemWait: begin
               cycle_d = sat_inc(cycle_q);
               stall_d = sat_inc(stall_q);
               if (MemReady) begin
                  Commit  = 1'b1;
                  instr_d = sat_inc(instr_q);
                  pc_d    = pc_next;
                  state_d = StRun;
               end else if (wait_q == WaitW'(MEM_TIMEOUT)) begin
                  state_d = StDone;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers; reset aborts immediately to IDLE.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
         pc_q    <= PC_W'(START_PC);
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         cycle_q <= '0;
         instr_q <= '0;
         stall_q <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         cycle_q <= cycle_d;
         instr_q <= instr_d;
         stall_q <= stall_d;
         wait_q  <= wait_d;
      end
   end

   assign Ack     = ack_q;
   assign Err     = err_q;
   assign PC      = pc_q;
   assign CycleCt = cycle_q;
   assign InstrCt = instr_q;
   assign StallCt = stall_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Bench for seq_run_ctrl: commit PCs are pushed to a scoreboard as stimulus is driven
// and popped whenever the DUT raises Commit; counters and handshake are checked inline.
module tb_seq_run_ctrl;

   localparam int unsigned CntW = 5;

   logic            Clk = 1'b0;
   logic            Reset_n = 1'b0;
   logic            Start = 1'b0;
   logic            Halt = 1'b0;
   logic            Branch = 1'b0;
   logic [7:0]      Target = 8'h00;
   logic            MemReq = 1'b0;
   logic            MemReady = 1'b0;
   logic            Ack, Err, Commit, ClearFlags;
   logic [7:0]      PC;
   logic [CntW-1:0] CycleCt, InstrCt, StallCt;

   int checks = 0;
   int errors = 0;
   int cf_cnt = 0;
   logic [7:0] exp_q[$];

   seq_run_ctrl #(
      .PC_W(8),
      .START_PC(0),
      .CNT_W(CntW),
      .MEM_TIMEOUT(15)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .Start(Start),
      .Halt(Halt),
      .Branch(Branch),
      .Target(Target),
      .MemReq(MemReq),
      .MemReady(MemReady),
`ifdef SEQ_SINGLE_STEP_EN
      .StepMode(1'b0),
      .Step(1'b0),
`endif
      .Ack(Ack),
      .Err(Err),
      .PC(PC),
      .Commit(Commit),
      .ClearFlags(ClearFlags),
      .CycleCt(CycleCt),
      .InstrCt(InstrCt),
      .StallCt(StallCt)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // One clock: sample combinational strobes mid-cycle, score any commit, advance.
   task automatic tick();
      logic [7:0] e;
      #1;
      if (Commit === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected got commit at pc=%0h required none", PC);
         end else begin
            e = exp_q.pop_front();
            if (PC !== e) begin
               errors++;
               $display("FAIL commit_pc got %0h required %0h", PC, e);
            end
         end
      end
      if (ClearFlags === 1'b1) cf_cnt++;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic commit_tick(input logic [7:0] p);
      exp_q.push_back(p);
      tick();
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s missing_commits got %0d pending required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      @(negedge Clk);
      checks++; if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc got %0h required 0", PC); end
      checks++; if (Ack !== 1'b0 || Err !== 1'b0) begin errors++;
         $display("FAIL reset_ack_err got %b%b required 00", Ack, Err); end
      checks++; if (CycleCt !== '0 || InstrCt !== '0 || StallCt !== '0) begin errors++;
         $display("FAIL reset_counters got %0d/%0d/%0d required 0/0/0", CycleCt, InstrCt, StallCt); end
      checks++; if (Commit !== 1'b0 || ClearFlags !== 1'b0) begin errors++;
         $display("FAIL reset_strobes got %b%b required 00", Commit, ClearFlags); end
      Reset_n = 1'b1;
      tick();
      checks++; if (ClearFlags !== 1'b0 || PC !== 8'h00) begin errors++;
         $display("FAIL idle_hold got cf=%b pc=%0h required cf=0 pc=0", ClearFlags, PC); end
   endtask

   task automatic test_basic();
      cf_cnt = 0;
      Start = 1'b1; tick();
      tick();
      Start = 1'b0; tick();
      checks++; if (cf_cnt != 2) begin errors++;
         $display("FAIL basic_clearflags got %0d cycles required 2", cf_cnt); end
      for (int p = 0; p < 5; p++) commit_tick(8'(p));
      Halt = 1'b1; tick(); Halt = 1'b0;
      checks++; if (Ack !== 1'b1 || Err !== 1'b0) begin errors++;
         $display("FAIL basic_ack got ack=%b err=%b required 1 0", Ack, Err); end
      checks++; if (PC !== 8'h05) begin errors++; $display("FAIL basic_pc got %0h required 5", PC); end
      checks++; if (InstrCt !== 5'd5) begin errors++;
         $display("FAIL basic_instr got %0d required 5", InstrCt); end
      checks++; if (CycleCt !== 5'd6) begin errors++;
         $display("FAIL basic_cycle got %0d required 6", CycleCt); end
      checks++; if (StallCt !== 5'd0) begin errors++;
         $display("FAIL basic_stall got %0d required 0", StallCt); end
      check_drained("basic");
      tick();
      checks++; if (Ack !== 1'b1 || PC !== 8'h05 || CycleCt !== 5'd6) begin errors++;
         $display("FAIL done_hold got ack=%b pc=%0h cyc=%0d required 1 5 6", Ack, PC, CycleCt); end
   endtask

   task automatic test_branch();
      Start = 1'b1; tick();
      Start = 1'b0; tick();
      for (int p = 0; p < 3; p++) commit_tick(8'(p));
      Branch = 1'b1; Target = 8'h20; commit_tick(8'h03);
      checks++; if (PC !== 8'h20) begin errors++; $display("FAIL branch_taken got %0h required 20", PC); end
      Target = 8'hFE; commit_tick(8'h20);
      Branch = 1'b0;
      commit_tick(8'hFE);
      checks++; if (PC !== 8'hFF) begin errors++; $display("FAIL branch_inc got %0h required ff", PC); end
      commit_tick(8'hFF);
      checks++; if (PC !== 8'h00) begin errors++; $display("FAIL pc_wrap got %0h required 0", PC); end
      checks++; if (InstrCt !== 5'd7 || CycleCt !== 5'd7) begin errors++;
         $display("FAIL branch_counts got %0d/%0d required 7/7", InstrCt, CycleCt); end
      check_drained("branch");
   endtask

   task automatic test_memwait();
      Start = 1'b1; tick();
      Start = 1'b0; tick();
      commit_tick(8'h00);
      commit_tick(8'h01);
      // Branch asserted throughout the stall must be ignored until commit.
      MemReq = 1'b1; MemReady = 1'b0; Branch = 1'b1; Target = 8'h40;
      tick();
      tick();
      Halt = 1'b1; tick(); Halt = 1'b0;
      checks++; if (PC !== 8'h02 || Ack !== 1'b0) begin errors++;
         $display("FAIL mem_hold got pc=%0h ack=%b required 2 0", PC, Ack); end
      MemReady = 1'b1; Branch = 1'b0; commit_tick(8'h02);
      checks++; if (PC !== 8'h03) begin errors++; $display("FAIL mem_advance got %0h required 3", PC); end
      checks++; if (StallCt !== 5'd3) begin errors++;
         $display("FAIL mem_stall got %0d required 3", StallCt); end
      checks++; if (InstrCt !== 5'd3 || CycleCt !== 5'd6) begin errors++;
         $display("FAIL mem_counts got %0d/%0d required 3/6", InstrCt, CycleCt); end
      // Memory ready in the same cycle: no stall.
      commit_tick(8'h03);
      MemReq = 1'b0; MemReady = 1'b0;
      checks++; if (PC !== 8'h04 || StallCt !== 5'd3) begin errors++;
         $display("FAIL mem_fast got pc=%0h stall=%0d required 4 3", PC, StallCt); end
      check_drained("memwait");
   endtask

   task automatic test_timeout();
      Start = 1'b1; tick();
      Start = 1'b0; tick();
      MemReq = 1'b1; MemReady = 1'b0;
      tick();
      repeat (14) tick();
      checks++; if (Ack !== 1'b0 || Err !== 1'b0) begin errors++;
         $display("FAIL timeout_early got ack=%b err=%b required 0 0", Ack, Err); end
      tick();
      checks++; if (Ack !== 1'b1 || Err !== 1'b1) begin errors++;
         $display("FAIL timeout_err got ack=%b err=%b required 1 1", Ack, Err); end
      checks++; if (StallCt !== 5'd15 || CycleCt !== 5'd16 || InstrCt !== 5'd0) begin errors++;
         $display("FAIL timeout_counts got %0d/%0d/%0d required 15/16/0", StallCt, CycleCt, InstrCt); end
      checks++; if (PC !== 8'h00) begin errors++; $display("FAIL timeout_pc got %0h required 0", PC); end
      MemReady = 1'b1; tick();
      MemReq = 1'b0; MemReady = 1'b0;
      checks++; if (Ack !== 1'b1 || StallCt !== 5'd15) begin errors++;
         $display("FAIL timeout_hold got ack=%b stall=%0d required 1 15", Ack, StallCt); end
      check_drained("timeout");
   endtask

   task automatic test_start_done();
      Start = 1'b1; tick();
      checks++; if (ClearFlags !== 1'b1) begin errors++;
         $display("FAIL restart_done_state got cf=%b required 1", ClearFlags); end
      checks++; if (PC !== 8'h00 || Ack !== 1'b0 || Err !== 1'b0) begin errors++;
         $display("FAIL restart_done_regs got pc=%0h ack=%b err=%b required 0 0 0", PC, Ack, Err); end
      checks++; if (CycleCt !== '0 || InstrCt !== '0 || StallCt !== '0) begin errors++;
         $display("FAIL restart_done_cnt got %0d/%0d/%0d required 0/0/0", CycleCt, InstrCt, StallCt); end
      Start = 1'b0;
   endtask

   task automatic test_start_memwait();
      tick();
      for (int p = 0; p < 4; p++) commit_tick(8'(p));
      MemReq = 1'b1; MemReady = 1'b0; tick();
      tick();
      // Start must beat MemReady: no commit here.
      Start = 1'b1; MemReady = 1'b1; tick();
      checks++; if (ClearFlags !== 1'b1 || PC !== 8'h00) begin errors++;
         $display("FAIL restart_mem got cf=%b pc=%0h required 1 0", ClearFlags, PC); end
      checks++; if (CycleCt !== '0 || InstrCt !== '0 || StallCt !== '0 || Ack !== 1'b0) begin errors++;
         $display("FAIL restart_mem_cnt got %0d/%0d/%0d ack=%b required 0/0/0 0",
                  CycleCt, InstrCt, StallCt, Ack); end
      Start = 1'b0; MemReq = 1'b0; MemReady = 1'b0;
      check_drained("start_memwait");
   endtask

   task automatic test_async_reset();
      tick();
      for (int p = 0; p < 3; p++) commit_tick(8'(p));
      #2 Reset_n = 1'b0;
      #1;
      checks++; if (PC !== 8'h00) begin errors++; $display("FAIL areset_pc got %0h required 0", PC); end
      checks++; if (CycleCt !== '0 || InstrCt !== '0) begin errors++;
         $display("FAIL areset_cnt got %0d/%0d required 0/0", CycleCt, InstrCt); end
      checks++; if (Commit !== 1'b0) begin errors++;
         $display("FAIL areset_commit got %b required 0", Commit); end
      @(negedge Clk);
      Reset_n = 1'b1;
      tick();
      checks++; if (PC !== 8'h00 || CycleCt !== '0 || Ack !== 1'b0) begin errors++;
         $display("FAIL areset_idle got pc=%0h cyc=%0d ack=%b required 0 0 0", PC, CycleCt, Ack); end
      check_drained("async_reset");
   endtask

   task automatic test_saturation();
      Start = 1'b1; tick();
      Start = 1'b0; tick();
      for (int p = 0; p < 35; p++) commit_tick(8'(p));
      checks++; if (InstrCt !== 5'd31 || CycleCt !== 5'd31) begin errors++;
         $display("FAIL saturate got %0d/%0d required 31/31", InstrCt, CycleCt); end
      checks++; if (PC !== 8'd35) begin errors++; $display("FAIL saturate_pc got %0d required 35", PC); end
      check_drained("saturation");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_branch();
      test_memwait();
      test_timeout();
      test_start_done();
      test_start_memwait();
      test_async_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
